// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiply and restoring divide,
// one add/subtract step per cycle, valid/ready on both the request and the result side.
module mdu_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int WW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            stateReg, stateNext;
    logic [2:0]        opReg;
    logic              isWordReg;
    logic              negReg;
    logic [CNT_W-1:0]  cntReg;
    logic [2*XLEN-1:0] accReg;
    logic [XLEN-1:0]   operandReg;
    logic [XLEN-1:0]   resultReg;

    function automatic logic [XLEN-1:0] wordFix(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-WW){v[WW-1]}}, v[WW-1:0]} : v;
    endfunction

    // ---------------- request decode and operand preparation ----------------
    logic              isDivIn, signed1In, signed2In;
    logic              negAIn, negBIn, negIn;
    logic              divZero, divOvf, specialIn;
    logic              accept, stepEn;
    logic [XLEN-1:0]   extA, extB, absA, absB, mostNeg;
    logic [XLEN-1:0]   specialRaw, specialResult, initOperand;
    logic [2*XLEN-1:0] initAcc;
    logic [CNT_W-1:0]  initCnt;

    always_comb begin
        isDivIn   = op[2];
        signed1In = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        signed2In = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        extA      = is_word ? {{(XLEN-WW){signed1In & src1[WW-1]}}, src1[WW-1:0]} : src1;
        extB      = is_word ? {{(XLEN-WW){signed2In & src2[WW-1]}}, src2[WW-1:0]} : src2;
        negAIn    = signed1In & extA[XLEN-1];
        negBIn    = signed2In & extB[XLEN-1];
        absA      = negAIn ? -extA : extA;
        absB      = negBIn ? -extB : extB;
        // Remainder takes the dividend's sign; quotient and product take the xor.
        negIn     = (isDivIn && op[1]) ? negAIn : (negAIn ^ negBIn);
        mostNeg   = is_word ? {{(XLEN-WW+1){1'b1}}, {(WW-1){1'b0}}}
                            : {1'b1, {(XLEN-1){1'b0}}};
        divZero   = isDivIn && (extB == '0);
        divOvf    = isDivIn && !op[0] && (extA == mostNeg) && (extB == '1);
        specialIn = divZero || divOvf;
        if (divZero) begin
            specialRaw = op[1] ? extA : '1;
        end else begin
            specialRaw = op[1] ? '0 : extA;
        end
        specialResult = wordFix(is_word, specialRaw);
        // W divides park the 32-bit dividend at the top of the quotient half so 32 shifts suffice.
        if (isDivIn) begin
            initAcc     = {{XLEN{1'b0}}, (is_word ? {absA[WW-1:0], {(XLEN-WW){1'b0}}} : absA)};
            initOperand = absB;
        end else begin
            initAcc     = {{XLEN{1'b0}}, absB};
            initOperand = absA;
        end
        initCnt = is_word ? CNT_W'(WW) : CNT_W'(XLEN);
        accept  = (stateReg == IDLE) && in_valid && !flush;
        stepEn  = (stateReg == BUSY) && !flush;
    end

    // ---------------- one iteration and final result shaping ----------------
    logic [XLEN:0]     mulSum, trial;
    logic [2*XLEN:0]   shifted;
    logic [2*XLEN-1:0] stepAcc, prod, prodSigned;
    logic [XLEN-1:0]   quo, rem, rawResult, finalResult;

    always_comb begin
        mulSum  = {1'b0, accReg[2*XLEN-1:XLEN]} + (accReg[0] ? {1'b0, operandReg} : '0);
        shifted = {accReg, 1'b0};
        trial   = shifted[2*XLEN:XLEN] - {1'b0, operandReg};
        if (opReg[2]) begin
            stepAcc = trial[XLEN] ? shifted[2*XLEN-1:0]
                                  : {trial[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
        end else begin
            stepAcc = {mulSum, accReg[XLEN-1:1]};
        end
        // After only 32 multiply steps the product still sits 32 bits up.
        prod       = isWordReg ? (stepAcc >> WW) : stepAcc;
        prodSigned = negReg ? -prod : prod;
        quo        = stepAcc[XLEN-1:0];
        rem        = stepAcc[2*XLEN-1:XLEN];
        if (opReg[2]) begin
            rawResult = opReg[1] ? (negReg ? -rem : rem) : (negReg ? -quo : quo);
        end else begin
            rawResult = (opReg == 3'd0) ? prodSigned[XLEN-1:0] : prodSigned[2*XLEN-1:XLEN];
        end
        finalResult = wordFix(isWordReg, rawResult);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (in_valid && !flush) begin
                    stateNext = specialIn ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (cntReg == CNT_W'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (stateReg == IDLE);
        out_valid = (stateReg == DONE);
        busy      = (stateReg != IDLE);
        result    = resultReg;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opReg      <= '0;
            isWordReg  <= 1'b0;
            negReg     <= 1'b0;
            cntReg     <= '0;
            accReg     <= '0;
            operandReg <= '0;
            resultReg  <= '0;
        end else if (accept) begin
            opReg      <= op;
            isWordReg  <= is_word;
            negReg     <= negIn;
            cntReg     <= initCnt;
            accReg     <= initAcc;
            operandReg <= initOperand;
            if (specialIn) begin
                resultReg <= specialResult;
            end
        end else if (stepEn) begin
            accReg <= stepAcc;
            cntReg <= cntReg - CNT_W'(1);
            if (cntReg == CNT_W'(1)) begin
                resultReg <= finalResult;
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases, flush/reset/backpressure scenarios and
// randomized operations compared against a plain-arithmetic RV64M reference model.
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic        is_word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    mdu_seq #(.XLEN(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_word(is_word), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] expVal);
        checks++;
        if (got !== expVal) begin
            failures++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, expVal);
        end
    endtask

    // Reference: RV64M semantics computed directly with wide/native integer arithmetic.
    function automatic logic [63:0] refModel(input logic [2:0] o, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic [31:0]  ua, ub, r32;
        int           sa, sb;
        longint       la, lb;
        logic [63:0]  r;
        if (w) begin
            ua = a[31:0];
            ub = b[31:0];
            sa = ua;
            sb = ub;
            r32 = '0;
            case (o)
                3'd0: r32 = ua * ub;
                3'd4: begin
                    if (ub == 0) r32 = '1;
                    else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
                    else r32 = 32'(sa / sb);
                end
                3'd5: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
                3'd6: begin
                    if (ub == 0) r32 = ua;
                    else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = '0;
                    else r32 = 32'(sa % sb);
                end
                3'd7: r32 = (ub == 0) ? ua : ua % ub;
                default: r32 = '0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        la = a;
        lb = b;
        r  = '0;
        case (o)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                ea = (o == 3'd3) ? {64'd0, a} : {{64{a[63]}}, a};
                eb = (o == 3'd2 || o == 3'd3) ? {64'd0, b} : {{64{b[63]}}, b};
                p  = ea * eb;
                r  = (o == 3'd0) ? p[63:0] : p[127:64];
            end
            3'd4: begin
                if (b == 0) r = ONES;
                else if (a == MIN64 && b == ONES) r = a;
                else r = 64'(la / lb);
            end
            3'd5: r = (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MIN64 && b == ONES) r = '0;
                else r = 64'(la % lb);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int expLatency(input logic [2:0] o, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        logic special;
        if (!o[2]) special = 1'b0;
        else if (w) special = (b[31:0] == 0) ||
                              (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else special = (b == 0) || (!o[0] && a == MIN64 && b == ONES);
        if (special) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return ONES;
            2: return MIN64;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one request, measure latency, check result, hold it for 'hold' cycles, then consume.
    task automatic runOp(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] expRes,
                         input int expLat, input int hold);
        int lat;
        logic [63:0] got;
        checkVal("in_ready_idle", in_ready, 1);
        op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkVal("busy_after_accept", busy, 1);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        got = result;
        checkVal("latency", lat, expLat);
        checkVal("result", got, expRes);
        checkVal("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkVal("hold_valid", out_valid, 1);
            checkVal("hold_result", result, expRes);
            checkVal("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal("ack_idle", {busy, out_valid, in_ready}, 3'b001);
        $display("txn op=%0d w=%0d a=%016h b=%016h result=%016h expect=%016h lat=%0d",
                 o, w, a, b, got, expRes, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ro;
        logic        rw;
        logic [63:0] ra, rb;
        logic        seen;

        #2;
        checkVal("rst_state", {in_ready, out_valid, busy}, 3'b100);
        checkVal("rst_result", result, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        runOp(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        runOp(3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        runOp(3'd1, 1'b0, ONES, ONES, 64'd0, 65, 0);
        runOp(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        runOp(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, 0);
        runOp(3'd5, 1'b1, 64'h1_0000_0010, 64'd4, 64'd4, 33, 0);
        runOp(3'd4, 1'b0, 64'd5, 64'd0, ONES, 1, 0);
        runOp(3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
        runOp(3'd4, 1'b0, MIN64, ONES, MIN64, 1, 0);
        runOp(3'd6, 1'b0, MIN64, ONES, 64'd0, 1, 0);
        runOp(3'd0, 1'b0, 64'd123, 64'd456, 64'd56088, 65, 10);

        // flush during BUSY
        op = 3'd1; is_word = 1'b0; src1 = 64'h1234_5678_9ABC_DEF0; src2 = 64'd99; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkVal("flush_busy", {busy, out_valid, in_ready}, 3'b001);
        seen = 1'b0;
        repeat (70) begin @(posedge clk); #1; seen = seen | out_valid; end
        checkVal("flush_no_valid", seen, 0);
        runOp(3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 65, 0);

        // flush beats in_valid in IDLE
        op = 3'd0; src1 = 64'd2; src2 = 64'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checkVal("flush_idle_no_accept", busy, 0);

        // flush together with out_ready in DONE discards the result
        op = 3'd5; is_word = 1'b0; src1 = 64'd9; src2 = 64'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkVal("done_before_flush", {out_valid, result}, {1'b1, ONES});
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        checkVal("flush_done", {busy, out_valid, in_ready}, 3'b001);

        // asynchronous reset mid-BUSY
        op = 3'd0; src1 = 64'd77; src2 = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checkVal("rst_mid_state", {in_ready, out_valid, busy}, 3'b100);
        checkVal("rst_mid_result", result, 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        runOp(3'd2, 1'b0, ONES, 64'd2, ONES, 65, 0);

        // randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            rw = (ro == 3'd1 || ro == 3'd2 || ro == 3'd3) ? 1'b0 : 1'($urandom_range(0, 1));
            ra = pick();
            rb = pick();
            runOp(ro, rw, ra, rb, refModel(ro, rw, ra, rb), expLatency(ro, rw, ra, rb),
                  int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
